c1541_sd_arbiter: RTL and testbench
===================================

// Module: c1541_sd_arbiter
// PURPOSE
//  Shares one host SD block interface (lba/rd/wr/ack/buffer) between NDRV c1541 drive
//  instances. Round-robin grants one drive's sector read or write at a time. Routes
//  buffer traffic and ack to the granted drive only. Sits in the clk_sys domain,
//  between the per-drive c1541_sd track buffers and the host-side sd_* ports.
// PARAMETERS
//  NDRV     4        number of drive requesters (1..4)
//  TMO_W    24       ack-timeout counter width; 0 disables the timeout
// PORTS
//  clk_sys        in   1        system clock
//  reset          in   1        synchronous, active-high reset
//  drv_rd         in   NDRV     per-drive read request (level)
//  drv_wr         in   NDRV     per-drive write request (level)
//  drv_lba        in   32*NDRV  per-drive LBA; drive i occupies bits [32*i+31:32*i]
//  drv_buff_din   in   8*NDRV   per-drive write data, indexed by sd_buff_addr
//  drv_ack        out  NDRV     sd_ack, routed to the granted drive only
//  drv_buff_wr    out  NDRV     sd_buff_wr, routed to the granted drive only
//  drv_tmo        out  NDRV     1-cycle pulse: the granted transfer was aborted by timeout
//  sd_lba         out  32       LBA of the granted request
//  sd_rd          out  1        host read strobe
//  sd_wr          out  1        host write strobe
//  sd_ack         in   1        host acknowledge, high for the whole transfer
//  sd_buff_wr     in   1        host write-into-drive-buffer strobe
//  sd_buff_din    out  8        drv_buff_din slice of the granted drive
//  sel            out  2        index of the granted drive
//  busy           out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; sd_rd=sd_wr=0, sd_lba=0, sel=0, rr pointer=0, all drv_* outputs 0.
//  FSM:
//   IDLE
//    - Scans for drive i with drv_rd[i]|drv_wr[i].
//    - Scan order starts at rr+1 mod NDRV, wraps, and ends with rr.
//    - On the first hit: latch sel=i and sd_lba=drv_lba[i].
//    - Set sd_wr=drv_wr[i]; set sd_rd=drv_rd[i]&~drv_wr[i] (write beats read for the same drive).
//    - Go to REQ. Grant latency: strobe is registered 1 clk after the request is seen.
//   REQ
//    - Holds the strobe and sd_lba stable.
//    - On sd_ack=1: clear sd_rd/sd_wr, go to XFER.
//   XFER
//    - On sd_ack=0: set rr=sel, go to IDLE.
//    - Next grant is possible on the following clk.
//  Timeout (TMO_W>0):
//   - Counter clears on entry to REQ and counts while in REQ.
//   - At all-ones: clear strobes, pulse drv_tmo[sel] for 1 clk, set rr=sel, go to IDLE.
//   - No timeout in XFER; the host owns ack duration.
//  Routing (combinational):
//   - drv_ack[i] = sd_ack & (sel==i) & (state!=IDLE).
//   - drv_buff_wr[i] = sd_buff_wr & drv_ack[i].
//   - sd_buff_din = drv_buff_din[sel] at all times.
//  Requests:
//   - Sampled only in IDLE. Changes to drv_lba/drv_rd/drv_wr after the grant are ignored
//     until the FSM is back in IDLE.
//   - A requester still high after its own completion stays eligible, but lowest priority.
//  Fairness: with all NDRV requesting continuously, grants rotate 0,1,..,NDRV-1,0.
//  Stray sd_ack while IDLE: ignored; no routing.
//  sel is 2 bits; indices >= NDRV are never granted.
//  Reset mid-transfer: FSM aborts to IDLE; no drv_tmo pulse; the host ack is simply ignored.
// STRUCTURE
//  - Package c1541_pkg: state enum {IDLE,REQ,XFER}; constant MAX_DRV=4.
//  - One sub-module: c1541_rr_pick, a pure combinational round-robin priority encoder
//    (req vector, rr -> valid, index).
//  - FSM, timeout counter and routing live in this module.
// TESTING
//  1. Read: drv_rd=4'b0100, lba=0x123 -> sel=2, sd_rd=1 next clk, sd_lba=0x123;
//     ack high -> sd_rd=0, drv_ack=4'b0100; ack low -> busy=0.
//  2. Simultaneous requests: drv_rd=4'b1111 held, rr=0 after reset, ack after 3 clk each
//     -> grant order 1,2,3,0,1.
//  3. Write routing: drv_wr[1]=1, host ack with 512 reads of sd_buff_din
//     -> each byte equals drv_buff_din[15:8] at that addr; drv_buff_wr stays 0.
//  4. Read routing: grant drive 3, host pulses sd_buff_wr 512 times
//     -> only drv_buff_wr[3] pulses, 512 times; drives 0..2 see nothing.
//  5. Timeout: TMO_W=4, no ack -> 15 clk after entering REQ, sd_rd drops,
//     drv_tmo[sel] pulses 1 clk, busy=0.
//  6. Reset mid-XFER while sd_ack=1 -> next clk busy=0, drv_ack=0, sd_rd=sd_wr=0, sel=0.

Source files
------------

// File: rtl/c1541_sd_arbiter_pkg.sv
// rtl/c1541_sd_arbiter_pkg.sv - shared types and constants for the c1541 SD arbiter
// Purpose: arbiter FSM state encoding and the hard upper bound on drive count.
// Ports: none (package).
package c1541_pkg;

  // sel is 2 bits wide, so no more than four drives can ever be addressed.
  localparam int MAX_DRV = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_e;

endpackage

// File: rtl/c1541_rr_pick.sv
// rtl/c1541_rr_pick.sv - combinational round-robin priority encoder
// Purpose: pick the first requester after the last-served index, wrapping around.
// Ports:
//   req   in  NDRV  request vector, one bit per drive
//   rr    in  2     index of the most recently served drive
//   valid out 1     some request is pending
//   idx   out 2     chosen drive index (only meaningful when valid)
module c1541_rr_pick
  import c1541_pkg::*;
#(
  parameter int NDRV = MAX_DRV
) (
  input  logic [NDRV-1:0] req,
  input  logic [1:0]      rr,
  output logic            valid,
  output logic [1:0]      idx
);

  // Scan rr+1, rr+2, ..., rr (mod NDRV): the last-served drive is checked last,
  // which is what makes a continuously-requesting drive lowest priority.
  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = rr;
    for (int k = 1; k <= NDRV; k++) begin
      j = (int'(rr) + k) % NDRV;
      if (!valid && req[2'(j)]) begin
        valid = 1'b1;
        idx   = 2'(j);
      end
    end
  end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// rtl/c1541_sd_arbiter.sv - round-robin share of one host SD block port among c1541 drives
// Purpose: grant one drive's sector read/write at a time to the host sd_* interface,
//          route ack and buffer traffic to the granted drive, abort on ack timeout.
// Ports:
//   clk_sys, reset                 clock, synchronous active-high reset
//   drv_rd/drv_wr [NDRV]           per-drive read/write request levels
//   drv_lba [32*NDRV]              per-drive LBA, drive i at [32*i+31:32*i]
//   drv_buff_din [8*NDRV]          per-drive write data
//   drv_ack/drv_buff_wr [NDRV]     host ack / buffer write routed to granted drive
//   drv_tmo [NDRV]                 one-cycle abort pulse for the granted drive
//   sd_lba, sd_rd, sd_wr           host request (registered)
//   sd_ack, sd_buff_wr             host acknowledge and buffer write strobe
//   sd_buff_din                    granted drive's write byte
//   sel, busy                      granted index, FSM not idle
module c1541_sd_arbiter
  import c1541_pkg::*;
#(
  parameter int NDRV  = 4,
  parameter int TMO_W = 24
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [NDRV-1:0]    drv_rd,
  input  logic [NDRV-1:0]    drv_wr,
  input  logic [32*NDRV-1:0] drv_lba,
  input  logic [8*NDRV-1:0]  drv_buff_din,
  output logic [NDRV-1:0]    drv_ack,
  output logic [NDRV-1:0]    drv_buff_wr,
  output logic [NDRV-1:0]    drv_tmo,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic               sd_buff_wr,
  output logic [7:0]         sd_buff_din,
  output logic [1:0]         sel,
  output logic               busy
);

  // A zero-width counter is not legal, so keep one bit and gate the compare.
  localparam int CW     = (TMO_W > 0) ? TMO_W : 1;
  localparam bit TMO_EN = (TMO_W > 0);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        rr_q, rr_d;
  logic [31:0]       lba_q, lba_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [NDRV-1:0]   tmo_q, tmo_d;
  logic              pick_valid;
  logic [1:0]        pick_idx;

  c1541_rr_pick #(
    .NDRV (NDRV)
  ) u_pick (
    .req   (drv_rd | drv_wr),
    .rr    (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    tmo_d   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          lba_d   = drv_lba[{pick_idx, 5'b00000} +: 32];
          // Write wins when a drive raises both request lines.
          wr_d    = drv_wr[pick_idx];
          rd_d    = drv_rd[pick_idx] & ~drv_wr[pick_idx];
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (TMO_EN && (&cnt_inc)) begin
          // The abort lands on the edge where the counter reaches all-ones.
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          tmo_d   = NDRV'(1) << sel_q;
          rr_d    = sel_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          rr_d    = sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Stray acks while idle must not reach any drive.
  assign drv_ack     = (sd_ack && state_q != IDLE) ? (NDRV'(1) << sel_q) : '0;
  assign drv_buff_wr = sd_buff_wr ? drv_ack : '0;
  assign sd_buff_din = drv_buff_din[{sel_q, 3'b000} +: 8];
  assign drv_tmo     = tmo_q;
  assign sd_lba      = lba_q;
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign sel         = sel_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// tb/tb_c1541_sd_arbiter.sv - directed self-checking bench for c1541_sd_arbiter
module tb_c1541_sd_arbiter;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic [3:0]   drv_rd, drv_wr;
  logic [127:0] drv_lba;
  logic [31:0]  drv_buff_din;
  logic [3:0]   drv_ack, drv_buff_wr, drv_tmo;
  logic [31:0]  sd_lba;
  logic         sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]   sd_buff_din;
  logic [1:0]   sel;
  logic         busy;
  logic [8:0]   buf_addr;

  int n_checks = 0;
  int n_fail   = 0;

  c1541_sd_arbiter #(
    .NDRV  (4),
    .TMO_W (4)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_lba      (drv_lba),
    .drv_buff_din (drv_buff_din),
    .drv_ack      (drv_ack),
    .drv_buff_wr  (drv_buff_wr),
    .drv_tmo      (drv_tmo),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .sel          (sel),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Drive-side track buffers: each drive presents a distinct byte pattern per address.
  always_comb begin
    drv_buff_din = '0;
    for (int i = 0; i < 4; i++)
      drv_buff_din[8*i +: 8] = buf_addr[7:0] ^ 8'(i * 17) ^ {buf_addr[8], 7'b0};
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; drv_rd = '0; drv_wr = '0; drv_lba = '0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; buf_addr = '0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_checks++; if ({sd_rd, sd_wr} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b exp 00", {sd_rd, sd_wr}); end
    n_checks++; if (sd_lba !== 32'h0) begin n_fail++; $display("FAIL reset_lba got %h exp 0", sd_lba); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d exp 0", sel); end
    n_checks++; if ({drv_ack, drv_buff_wr, drv_tmo} !== 12'h0) begin n_fail++; $display("FAIL reset_drv_outs got %h exp 0", {drv_ack, drv_buff_wr, drv_tmo}); end
    reset = 1'b0;
  endtask

  task automatic test_read();
    drv_lba[64 +: 32] = 32'h123;
    drv_rd = 4'b0100;
    tick();
    n_checks++; if ({sd_rd, sd_wr} !== 2'b10) begin n_fail++; $display("FAIL read_strobe got %b exp 10", {sd_rd, sd_wr}); end
    n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL read_sel got %0d exp 2", sel); end
    n_checks++; if (sd_lba !== 32'h123) begin n_fail++; $display("FAIL read_lba got %h exp 123", sd_lba); end
    // Post-grant request changes must be ignored.
    drv_rd = 4'b0000; drv_lba[64 +: 32] = 32'hdead;
    tick();
    n_checks++; if (sd_rd !== 1'b1 || sd_lba !== 32'h123) begin n_fail++; $display("FAIL read_hold got rd=%0b lba=%h exp rd=1 lba=123", sd_rd, sd_lba); end
    sd_ack = 1'b1;
    #1;
    n_checks++; if (drv_ack !== 4'b0100) begin n_fail++; $display("FAIL read_ack_route got %b exp 0100", drv_ack); end
    tick();
    n_checks++; if (sd_rd !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL read_xfer got rd=%0b busy=%0b exp rd=0 busy=1", sd_rd, busy); end
    sd_ack = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_done_busy got %0b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_order [5];
    exp_order = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset = 1'b1; tick(); reset = 1'b0;
    drv_rd = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_checks++; if (sel !== exp_order[g] || sd_rd !== 1'b1) begin n_fail++; $display("FAIL rr_grant%0d got sel=%0d rd=%0b exp sel=%0d rd=1", g, sel, sd_rd, exp_order[g]); end
      if (g == 4) drv_rd = 4'b0000;
      tick(); tick();
      sd_ack = 1'b1; tick();
      sd_ack = 1'b0; tick();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_end_busy got %0b exp 0", busy); end
  endtask

  task automatic test_write_routing();
    int bad;
    bad = 0;
    drv_wr = 4'b0010; drv_rd = 4'b0010;
    tick();
    n_checks++; if (sel !== 2'd1 || {sd_rd, sd_wr} !== 2'b01) begin n_fail++; $display("FAIL wr_grant got sel=%0d rdwr=%b exp sel=1 rdwr=01", sel, {sd_rd, sd_wr}); end
    drv_wr = 4'b0000; drv_rd = 4'b0000;
    sd_ack = 1'b1; tick();
    n_checks++; if (drv_ack !== 4'b0010) begin n_fail++; $display("FAIL wr_ack_route got %b exp 0010", drv_ack); end
    for (int a = 0; a < 512; a++) begin
      buf_addr = 9'(a);
      #2;
      if (sd_buff_din !== (8'(a) ^ 8'h11 ^ {buf_addr[8], 7'b0}) || drv_buff_wr !== 4'b0000) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wr_buff_din got %0d bad bytes exp 0", bad); end
    sd_ack = 1'b0; tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_done_busy got %0b exp 0", busy); end
  endtask

  task automatic test_read_routing();
    int cnt [4];
    cnt = '{0, 0, 0, 0};
    // Stray host activity while idle reaches nobody.
    sd_ack = 1'b1; sd_buff_wr = 1'b1; #1;
    n_checks++; if (drv_ack !== 4'b0 || drv_buff_wr !== 4'b0) begin n_fail++; $display("FAIL stray_ack got ack=%b bwr=%b exp 0000", drv_ack, drv_buff_wr); end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    drv_rd = 4'b1000;
    tick();
    n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL rd_route_sel got %0d exp 3", sel); end
    drv_rd = 4'b0000;
    sd_ack = 1'b1; tick();
    for (int p = 0; p < 512; p++) begin
      sd_buff_wr = 1'b1; tick();
      for (int i = 0; i < 4; i++) cnt[i] += int'(drv_buff_wr[i]);
      sd_buff_wr = 1'b0; tick();
      for (int i = 0; i < 4; i++) cnt[i] += int'(drv_buff_wr[i]);
    end
    n_checks++; if (cnt[3] != 512) begin n_fail++; $display("FAIL rd_route_d3 got %0d pulses exp 512", cnt[3]); end
    n_checks++; if (cnt[0] + cnt[1] + cnt[2] != 0) begin n_fail++; $display("FAIL rd_route_others got %0d pulses exp 0", cnt[0] + cnt[1] + cnt[2]); end
    sd_ack = 1'b0; tick();
  endtask

  task automatic test_timeout();
    int early_drop;
    early_drop = 0;
    drv_rd = 4'b0001;
    tick();
    n_checks++; if (sel !== 2'd0 || sd_rd !== 1'b1) begin n_fail++; $display("FAIL tmo_grant got sel=%0d rd=%0b exp sel=0 rd=1", sel, sd_rd); end
    drv_rd = 4'b0000;
    for (int k = 1; k < 15; k++) begin
      tick();
      if (sd_rd !== 1'b1 || drv_tmo !== 4'b0) early_drop++;
    end
    n_checks++; if (early_drop != 0) begin n_fail++; $display("FAIL tmo_early got %0d early cycles exp 0", early_drop); end
    tick();
    n_checks++; if (sd_rd !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_abort got rd=%0b busy=%0b exp 0 0", sd_rd, busy); end
    n_checks++; if (drv_tmo !== 4'b0001) begin n_fail++; $display("FAIL tmo_pulse got %b exp 0001", drv_tmo); end
    tick();
    n_checks++; if (drv_tmo !== 4'b0000) begin n_fail++; $display("FAIL tmo_pulse_len got %b exp 0000", drv_tmo); end
  endtask

  task automatic test_reset_mid_xfer();
    drv_wr = 4'b0100;
    tick();
    n_checks++; if (sel !== 2'd2 || sd_wr !== 1'b1) begin n_fail++; $display("FAIL rst_grant got sel=%0d wr=%0b exp sel=2 wr=1", sel, sd_wr); end
    sd_ack = 1'b1; tick();
    n_checks++; if (drv_ack !== 4'b0100) begin n_fail++; $display("FAIL rst_pre_ack got %b exp 0100", drv_ack); end
    reset = 1'b1; drv_wr = 4'b0000;
    tick();
    n_checks++; if (busy !== 1'b0 || drv_ack !== 4'b0) begin n_fail++; $display("FAIL rst_mid got busy=%0b ack=%b exp 0 0000", busy, drv_ack); end
    n_checks++; if ({sd_rd, sd_wr} !== 2'b00 || sel !== 2'd0 || drv_tmo !== 4'b0) begin n_fail++; $display("FAIL rst_mid_outs got rdwr=%b sel=%0d tmo=%b exp 00 0 0000", {sd_rd, sd_wr}, sel, drv_tmo); end
    reset = 1'b0; sd_ack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_write_routing();
    test_read_routing();
    test_timeout();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
